// File: rtl/pipe_pkg.sv
// Shared definitions for the inter-stage pipeline buffer: FSM encoding,
// CPU exception codes and default field widths.
package pipe_pkg;

  localparam int DEFAULT_DATA_WIDTH      = 54;
  localparam int DEFAULT_INST_ADDR_WIDTH = 16;
  localparam int DEFAULT_EXC_WIDTH       = 4;

  // Encoding doubles as the occupancy count.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  localparam logic [3:0] EXC_NONE     = 4'd0;
  localparam logic [3:0] EXC_INST_MEM = 4'd1;
  localparam logic [3:0] EXC_ALU      = 4'd2;
  localparam logic [3:0] EXC_DATA_MEM = 4'd3;
  localparam logic [3:0] EXC_REG_FILE = 4'd4;

endpackage

// File: rtl/pipe_stage_buffer_if.sv
// Upstream/downstream valid-ready bus of the stage buffer.
// master = the surrounding pipeline stages, slave = the buffer.
interface pipe_stage_buffer_if
  import pipe_pkg::*;
#(
  parameter int DATA_WIDTH      = DEFAULT_DATA_WIDTH,
  parameter int INST_ADDR_WIDTH = DEFAULT_INST_ADDR_WIDTH,
  parameter int EXC_WIDTH       = DEFAULT_EXC_WIDTH
) ();

  logic                       in_valid;
  logic                       in_ready;
  logic [DATA_WIDTH-1:0]      in_data;
  logic [INST_ADDR_WIDTH-1:0] in_pc;
  logic [EXC_WIDTH-1:0]       in_exc;
  logic                       out_valid;
  logic                       out_ready;
  logic [DATA_WIDTH-1:0]      out_data;
  logic [INST_ADDR_WIDTH-1:0] out_pc;
  logic [EXC_WIDTH-1:0]       out_exc;

  modport master (
    output in_valid, in_data, in_pc, in_exc, out_ready,
    input  in_ready, out_valid, out_data, out_pc, out_exc
  );

  modport slave (
    input  in_valid, in_data, in_pc, in_exc, out_ready,
    output in_ready, out_valid, out_data, out_pc, out_exc
  );

endinterface

// File: rtl/pipe_entry.sv
// Load-enabled register holding one packed {data, pc, exc} entry.
// Synchronous reset to zero; holds its value when load is low.
module pipe_entry #(
  parameter int WIDTH = 74
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk) begin
    if (rst)
      q <= '0;
    else if (load)
      q <= d;
  end

endmodule

// File: rtl/pipe_stage_buffer.sv
// Two-entry skid buffer between CPU stages with flush and sticky first-exception capture.
// One cycle in_fire->out_valid; in_ready comes only from registered state.
module pipe_stage_buffer
  import pipe_pkg::*;
#(
  parameter int DATA_WIDTH      = DEFAULT_DATA_WIDTH,
  parameter int INST_ADDR_WIDTH = DEFAULT_INST_ADDR_WIDTH,
  parameter int EXC_WIDTH       = DEFAULT_EXC_WIDTH
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  pipe_stage_buffer_if.slave         bus,
  output logic [1:0]                 occupancy,
  output logic                       exc_pending,
  output logic [INST_ADDR_WIDTH-1:0] exc_pc,
  output logic [EXC_WIDTH-1:0]       exc_code,
  input  logic                       exc_clear
);

  localparam int ENT_WIDTH = DATA_WIDTH + INST_ADDR_WIDTH + EXC_WIDTH;

  state_t               state;
  logic                 out_valid_q;
  logic                 in_ready_q;
  logic                 in_fire;
  logic                 out_fire;
  logic                 head_load;
  logic                 skid_load;
  logic [ENT_WIDTH-1:0] in_ent;
  logic [ENT_WIDTH-1:0] head_d;
  logic [ENT_WIDTH-1:0] head_ent;
  logic [ENT_WIDTH-1:0] skid_ent;
  logic                 capture;

  assign in_fire  = bus.in_valid & in_ready_q;
  assign out_fire = out_valid_q & bus.out_ready;
  assign in_ent   = {bus.in_data, bus.in_pc, bus.in_exc};
  assign capture  = out_fire & (bus.out_exc != EXC_WIDTH'(EXC_NONE)) & ~exc_pending;

  // Flush suppresses all payload loads; the registers simply keep their last value.
  always_comb begin
    head_load = 1'b0;
    skid_load = 1'b0;
    head_d    = in_ent;
    if (!flush) begin
      case (state)
        EMPTY: head_load = in_fire;
        ONE: begin
          head_load = in_fire & out_fire;
          skid_load = in_fire & ~out_fire;
        end
        FULL: begin
          head_load = out_fire;
          head_d    = skid_ent;
        end
        default: ;
      endcase
    end
  end

  pipe_entry #(.WIDTH(ENT_WIDTH)) u_head (
    .clk  (clk),
    .rst  (rst),
    .load (head_load),
    .d    (head_d),
    .q    (head_ent)
  );

  pipe_entry #(.WIDTH(ENT_WIDTH)) u_skid (
    .clk  (clk),
    .rst  (rst),
    .load (skid_load),
    .d    (in_ent),
    .q    (skid_ent)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= EMPTY;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
      exc_pending <= 1'b0;
      exc_pc      <= '0;
      exc_code    <= '0;
    end else begin
      if (flush) begin
        state       <= EMPTY;
        out_valid_q <= 1'b0;
        in_ready_q  <= 1'b1;
      end else begin
        case (state)
          EMPTY: if (in_fire) begin
            state       <= ONE;
            out_valid_q <= 1'b1;
          end
          ONE: begin
            if (in_fire && !out_fire) begin
              state      <= FULL;
              in_ready_q <= 1'b0;
            end else if (!in_fire && out_fire) begin
              state       <= EMPTY;
              out_valid_q <= 1'b0;
            end
          end
          FULL: if (out_fire) begin
            state      <= ONE;
            in_ready_q <= 1'b1;
          end
          default: begin
            state       <= EMPTY;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
          end
        endcase
      end

      // A retirement in a flush cycle still counts; capture beats a same-cycle clear.
      if (capture) begin
        exc_pending <= 1'b1;
        exc_pc      <= bus.out_pc;
        exc_code    <= bus.out_exc;
      end else if (exc_clear) begin
        exc_pending <= 1'b0;
      end
    end
  end

  assign occupancy     = state;
  assign bus.out_valid = out_valid_q;
  assign bus.in_ready  = in_ready_q;
  assign {bus.out_data, bus.out_pc, bus.out_exc} = head_ent;

endmodule

// File: tb/tb_pipe_stage_buffer.sv
// Bench for pipe_stage_buffer: directed vector table followed by random traffic
// compared against a queue-based model of the buffer.
module tb_pipe_stage_buffer;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        exc_clear;
  logic [1:0]  occupancy;
  logic        exc_pending;
  logic [15:0] exc_pc;
  logic [3:0]  exc_code;

  int total = 0;
  int bad   = 0;

  pipe_stage_buffer_if bus ();

  pipe_stage_buffer dut (
    .clk         (clk),
    .rst         (rst),
    .flush       (flush),
    .bus         (bus),
    .occupancy   (occupancy),
    .exc_pending (exc_pending),
    .exc_pc      (exc_pc),
    .exc_code    (exc_code),
    .exc_clear   (exc_clear)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst, flush, iv;
    logic [15:0] ipc;
    logic [3:0]  iexc;
    logic        ordy, clr;
    logic        ov, ir;
    logic [1:0]  occ;
    logic [15:0] opc;
    logic [3:0]  oexc;
    logic        pend;
    logic [15:0] epc;
    logic [3:0]  ecode;
  } vec_t;

  typedef struct {
    logic [53:0] d;
    logic [15:0] pc;
    logic [3:0]  e;
  } ent_t;

  localparam int NV = 29;
  vec_t vt[NV];
  ent_t mq[$];

  function automatic vec_t mk(int r, int f, int iv, int ipc, int iexc, int ordy, int clr,
                              int ov, int ir, int occ, int opc, int oexc,
                              int pend, int epc, int ecode);
    vec_t v;
    v.rst = r[0];   v.flush = f[0];  v.iv = iv[0];
    v.ipc = 16'(ipc); v.iexc = 4'(iexc);
    v.ordy = ordy[0]; v.clr = clr[0];
    v.ov = ov[0];   v.ir = ir[0];    v.occ = 2'(occ);
    v.opc = 16'(opc); v.oexc = 4'(oexc);
    v.pend = pend[0]; v.epc = 16'(epc); v.ecode = 4'(ecode);
    return v;
  endfunction

  function automatic logic [53:0] mkd(logic [15:0] pc);
    return {pc, ~pc, pc ^ 16'h5A5A, 6'h2A};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  initial begin
    logic        m_pend;
    logic [15:0] m_epc;
    logic [3:0]  m_code;

    rst = 1'b1; flush = 1'b0; exc_clear = 1'b0;
    bus.in_valid = 1'b0; bus.in_data = '0; bus.in_pc = '0; bus.in_exc = '0;
    bus.out_ready = 1'b0;

    //        rst f iv ipc     iexc rdy clr | ov ir occ opc     oexc pend epc     ecode
    vt[0]  = mk(1, 0, 1, 'h0100, 0, 0, 0,   0, 1, 0, 'h0000, 0,   0, 'h0000, 0);
    vt[1]  = mk(1, 0, 1, 'h0100, 0, 0, 0,   0, 1, 0, 'h0000, 0,   0, 'h0000, 0);
    vt[2]  = mk(0, 0, 1, 'h0000, 0, 1, 0,   1, 1, 1, 'h0000, 0,   0, 'h0000, 0);
    vt[3]  = mk(0, 0, 1, 'h0002, 0, 1, 0,   1, 1, 1, 'h0002, 0,   0, 'h0000, 0);
    vt[4]  = mk(0, 0, 1, 'h0004, 0, 1, 0,   1, 1, 1, 'h0004, 0,   0, 'h0000, 0);
    vt[5]  = mk(0, 0, 0, 'h0000, 0, 1, 0,   0, 1, 0, 'h0004, 0,   0, 'h0000, 0);
    vt[6]  = mk(0, 0, 1, 'h0010, 0, 0, 0,   1, 1, 1, 'h0010, 0,   0, 'h0000, 0);
    vt[7]  = mk(0, 0, 1, 'h0012, 0, 0, 0,   1, 0, 2, 'h0010, 0,   0, 'h0000, 0);
    vt[8]  = mk(0, 0, 1, 'h0014, 0, 0, 0,   1, 0, 2, 'h0010, 0,   0, 'h0000, 0);
    vt[9]  = mk(0, 0, 1, 'h0014, 0, 1, 0,   1, 1, 1, 'h0012, 0,   0, 'h0000, 0);
    vt[10] = mk(0, 0, 1, 'h0014, 0, 1, 0,   1, 1, 1, 'h0014, 0,   0, 'h0000, 0);
    vt[11] = mk(0, 0, 0, 'h0000, 0, 1, 0,   0, 1, 0, 'h0014, 0,   0, 'h0000, 0);
    vt[12] = mk(0, 0, 1, 'h0040, 0, 0, 0,   1, 1, 1, 'h0040, 0,   0, 'h0000, 0);
    vt[13] = mk(0, 0, 1, 'h0042, 0, 0, 0,   1, 0, 2, 'h0040, 0,   0, 'h0000, 0);
    vt[14] = mk(0, 1, 1, 'h0044, 0, 0, 0,   0, 1, 0, 'h0040, 0,   0, 'h0000, 0);
    vt[15] = mk(0, 0, 0, 'h0000, 0, 1, 0,   0, 1, 0, 'h0040, 0,   0, 'h0000, 0);
    vt[16] = mk(0, 0, 1, 'h0020, 3, 0, 0,   1, 1, 1, 'h0020, 3,   0, 'h0000, 0);
    vt[17] = mk(0, 0, 1, 'h0022, 1, 1, 0,   1, 1, 1, 'h0022, 1,   1, 'h0020, 3);
    vt[18] = mk(0, 0, 0, 'h0000, 0, 1, 0,   0, 1, 0, 'h0022, 1,   1, 'h0020, 3);
    vt[19] = mk(0, 0, 0, 'h0000, 0, 0, 1,   0, 1, 0, 'h0022, 1,   0, 'h0020, 3);
    vt[20] = mk(0, 0, 1, 'h0030, 2, 0, 0,   1, 1, 1, 'h0030, 2,   0, 'h0020, 3);
    vt[21] = mk(0, 0, 0, 'h0000, 0, 1, 1,   0, 1, 0, 'h0030, 2,   1, 'h0030, 2);
    vt[22] = mk(0, 0, 0, 'h0000, 0, 0, 1,   0, 1, 0, 'h0030, 2,   0, 'h0030, 2);
    vt[23] = mk(0, 0, 1, 'h0050, 4, 0, 0,   1, 1, 1, 'h0050, 4,   0, 'h0030, 2);
    vt[24] = mk(0, 1, 1, 'h0052, 0, 1, 0,   0, 1, 0, 'h0050, 4,   1, 'h0050, 4);
    vt[25] = mk(0, 0, 1, 'h0060, 0, 0, 0,   1, 1, 1, 'h0060, 0,   1, 'h0050, 4);
    vt[26] = mk(0, 0, 1, 'h0062, 0, 0, 0,   1, 0, 2, 'h0060, 0,   1, 'h0050, 4);
    vt[27] = mk(1, 0, 1, 'h0064, 0, 0, 0,   0, 1, 0, 'h0000, 0,   0, 'h0000, 0);
    vt[28] = mk(0, 0, 0, 'h0000, 0, 0, 0,   0, 1, 0, 'h0000, 0,   0, 'h0000, 0);

    for (int i = 0; i < NV; i++) begin
      rst = vt[i].rst; flush = vt[i].flush; exc_clear = vt[i].clr;
      bus.in_valid = vt[i].iv; bus.in_pc = vt[i].ipc; bus.in_exc = vt[i].iexc;
      bus.in_data = mkd(vt[i].ipc); bus.out_ready = vt[i].ordy;
      @(posedge clk); #1;
      check($sformatf("v%0d out_valid", i), 64'(bus.out_valid), 64'(vt[i].ov));
      check($sformatf("v%0d in_ready", i), 64'(bus.in_ready), 64'(vt[i].ir));
      check($sformatf("v%0d occupancy", i), 64'(occupancy), 64'(vt[i].occ));
      check($sformatf("v%0d out_pc", i), 64'(bus.out_pc), 64'(vt[i].opc));
      check($sformatf("v%0d out_exc", i), 64'(bus.out_exc), 64'(vt[i].oexc));
      check($sformatf("v%0d exc_pending", i), 64'(exc_pending), 64'(vt[i].pend));
      check($sformatf("v%0d exc_pc", i), 64'(exc_pc), 64'(vt[i].epc));
      check($sformatf("v%0d exc_code", i), 64'(exc_code), 64'(vt[i].ecode));
      if (vt[i].rst)
        check($sformatf("v%0d reset out_data", i), 64'(bus.out_data), 64'd0);
      else if (vt[i].ov)
        check($sformatf("v%0d out_data", i), 64'(bus.out_data), 64'(mkd(vt[i].opc)));
    end

    // Random traffic; the table leaves the buffer empty with no exception recorded.
    m_pend = 1'b0; m_epc = '0; m_code = '0;
    mq.delete();
    bus.in_valid = 1'b0;
    for (int c = 0; c < 800; c++) begin
      ent_t ne;
      logic ofire, ifire, cap;
      check("rnd out_valid", 64'(bus.out_valid), 64'(mq.size() != 0));
      check("rnd in_ready", 64'(bus.in_ready), 64'(mq.size() < 2));
      check("rnd occupancy", 64'(occupancy), 64'(mq.size()));
      check("rnd exc_pending", 64'(exc_pending), 64'(m_pend));
      check("rnd exc_pc", 64'(exc_pc), 64'(m_epc));
      check("rnd exc_code", 64'(exc_code), 64'(m_code));
      if (mq.size() != 0) begin
        check("rnd out_pc", 64'(bus.out_pc), 64'(mq[0].pc));
        check("rnd out_exc", 64'(bus.out_exc), 64'(mq[0].e));
        check("rnd out_data", 64'(bus.out_data), 64'(mq[0].d));
      end

      // Upstream keeps a stalled entry stable until it is accepted.
      if (!(bus.in_valid && mq.size() == 2)) begin
        bus.in_valid = ($urandom_range(0, 3) != 0);
        bus.in_pc    = 16'($urandom);
        bus.in_data  = {22'($urandom), 32'($urandom)};
        bus.in_exc   = ($urandom_range(0, 4) == 0) ? 4'($urandom_range(1, 15)) : 4'd0;
      end
      bus.out_ready = ($urandom_range(0, 2) != 0);
      flush         = ($urandom_range(0, 15) == 0);
      exc_clear     = ($urandom_range(0, 9) == 0);

      ofire = (mq.size() != 0) && bus.out_ready;
      ifire = bus.in_valid && (mq.size() < 2);
      cap   = ofire && (mq[0].e != 4'd0) && !m_pend;
      if (cap) begin
        m_pend = 1'b1; m_epc = mq[0].pc; m_code = mq[0].e;
      end else if (exc_clear) begin
        m_pend = 1'b0;
      end
      if (ofire) void'(mq.pop_front());
      if (flush) mq.delete();
      else if (ifire) begin
        ne.d = bus.in_data; ne.pc = bus.in_pc; ne.e = bus.in_exc;
        mq.push_back(ne);
      end

      @(posedge clk); #1;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pipe_stage_buffer.md
Name: pipe_stage_buffer

Overview:
- Parametrised pipeline-register successor for the 16-bit CPU's inter-stage buffers.
- Carries a payload, the PC and an exception code between two stages.
- Uses a valid/ready handshake, so a stalled downstream stage back-pressures upstream without losing data.
- Two-entry skid storage keeps full throughput; it adds synchronous flush and sticky first-exception capture (EPC) for precise halt/exception handling.

Parameters:
- DATA_WIDTH, 54, payload width in bits (control bits plus operands).
- INST_ADDR_WIDTH, 16, PC width in bits.
- EXC_WIDTH, 4, exception-code width; the value 0 means no exception.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous active-high reset.
- flush  input  1  discard all buffered entries.
- in_valid  input  1  upstream presents an entry.
- in_ready  output  1  buffer can accept an entry this cycle.
- in_data  input  DATA_WIDTH  payload.
- in_pc  input  INST_ADDR_WIDTH  PC of the entry.
- in_exc  input  EXC_WIDTH  exception code of the entry.
- out_valid  output  1  head entry valid.
- out_ready  input  1  downstream accepts the head entry.
- out_data  output  DATA_WIDTH  head payload.
- out_pc  output  INST_ADDR_WIDTH  head PC.
- out_exc  output  EXC_WIDTH  head exception code.
- occupancy  output  2  entries held (0..2).
- exc_pending  output  1  sticky flag: an exception has retired.
- exc_pc  output  INST_ADDR_WIDTH  PC of the first retired exception.
- exc_code  output  EXC_WIDTH  code of the first retired exception.
- exc_clear  input  1  clear exc_pending.

Behaviour:
- Clock and reset: one clock, clk; reset is synchronous, active-high, on rst.
- Reset values:
  - state EMPTY; out_valid=0; in_ready=1; occupancy=0.
  - out_data, out_pc, out_exc, skid storage, exc_pc and exc_code all reset to 0.
  - exc_pending=0.
- Handshake:
  - in_fire = in_valid & in_ready; out_fire = out_valid & out_ready.
  - in_ready depends only on the state register (no combinational path from out_ready).
  - in_ready = (state != FULL).
  - Upstream must hold in_* stable while in_valid=1 and in_ready=0.
- Latency: 1 cycle from in_fire to out_valid. Throughput is 1 entry/cycle when out_ready stays high.
- FSM states: EMPTY (0), ONE (1), FULL (2). The value of occupancy equals the state encoding.
- FSM transitions:
  - EMPTY:
    - in_fire -> ONE, head<=in.
    - Otherwise stay EMPTY.
  - ONE:
    - in_fire & out_fire -> ONE, head<=in.
    - in_fire & !out_fire -> FULL, skid<=in.
    - !in_fire & out_fire -> EMPTY.
    - Otherwise hold.
  - FULL:
    - out_fire -> ONE, head<=skid.
    - Otherwise hold. No in_fire is possible here.
- Ordering: entries leave strictly in arrival order; the skid entry is never exposed at the head before the current head retires.
- Flush:
  - Next state is EMPTY, out_valid=0, in_ready=1.
  - An in_fire in the same cycle is discarded.
  - An out_fire in the same cycle still counts as retired, including for exception capture.
  - Priority: rst > flush > normal operation.
- Payload registers: hold their last value when EMPTY. They are never X after reset.
- Exception capture:
  - Trigger: out_fire & (out_exc != 0) & !exc_pending.
  - Action: exc_pending<=1, exc_pc<=out_pc, exc_code<=out_exc.
  - Later exceptions are ignored while exc_pending=1.
  - exc_clear clears exc_pending. If clear and a new capture occur in the same cycle, the capture wins (flag stays 1, new pc/code loaded).
  - flush does not affect the exception registers.
- Widths: no arithmetic beyond the 2-bit state. No wrap-around is possible because occupancy saturates at FULL.

Decomposition:
- Shared package (pipe_pkg):
  - State encodings EMPTY/ONE/FULL.
  - EXC_NONE=0 and the CPU exception codes (inst memory, ALU, data memory, reg file).
  - Default widths: DATA_WIDTH=54, INST_ADDR_WIDTH=16, EXC_WIDTH=4.
- Sub-module: pipe_entry.
  - A load-enabled register bundling {data, pc, exc} with synchronous reset to 0.
  - Instantiated twice, as head and skid.

Test Plan:
- Reset: hold rst high 2 cycles with in_valid=1 -> out_valid=0, in_ready=1, occupancy=0, exc_pending=0, all outputs 0.
- Streaming: out_ready=1, push PCs 0x0000,0x0002,0x0004 on consecutive cycles -> out_valid 1 cycle later, the same PCs in order on consecutive cycles, occupancy stays 1.
- Back-pressure: out_ready=0, push 0x0010 then 0x0012 -> occupancy 2, in_ready=0, 0x0014 held upstream. Then out_ready=1 -> outputs 0x0010, 0x0012, 0x0014 in order with no loss or duplicate.
- Flush while FULL, with in_valid=1 in the same cycle -> next cycle occupancy=0, out_valid=0, in_ready=1, and the incoming entry never appears.
- Exceptions:
  - Retire PC 0x0020 with exc=3, then PC 0x0022 with exc=1 -> exc_pending=1, exc_pc=0x0020, exc_code=3 (second exception ignored).
  - Pulse exc_clear in the same cycle as retiring PC 0x0030 with exc=2 -> exc_pending stays 1, exc_pc=0x0030, exc_code=2.
- Reset mid-operation while FULL with exc_pending=1 -> all state and outputs return to reset values next cycle.
